// File: rtl/wave_switch_ctrl.sv
// Glitch-free waveform switch: ramps gain to zero, commits the new mode on an
// oscillator period boundary (or after a timeout), then ramps gain back up.
module wave_switch_ctrl #(
    parameter int RAMP_DIV     = 4,
    parameter int RAMP_STEP    = 64,
    parameter int WRAP_TIMEOUT = 1024
) (
    input  logic       MHz10,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req_mode,
    input  logic       phase_wrap,
    output logic [2:0] active_mode,
    output logic [7:0] gain,
    output logic       busy
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int TW = (WRAP_TIMEOUT > 1) ? $clog2(WRAP_TIMEOUT) : 1;
    localparam logic [PW-1:0] PRESC_LAST   = PW'(RAMP_DIV - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(WRAP_TIMEOUT - 1);
    localparam logic [8:0]    STEP         = 9'(RAMP_STEP);
    localparam logic [8:0]    GAIN_MAX     = 9'd255;

    typedef enum logic [1:0] {RUN, RAMP_DOWN, WAIT_WRAP, RAMP_UP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    target_q, target_d;
    logic [PW-1:0] presc_q, presc_d, presc_inc;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    mode_d;
    logic [7:0]    gain_d;
    logic [8:0]    gain_dn, gain_up;
    logic          legal, changed, tick;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d   = state_q;
        target_d  = target_q;
        presc_d   = presc_q;
        tcnt_d    = tcnt_q;
        mode_d    = active_mode;
        gain_d    = gain;
        legal     = (req_mode != 3'd7);
        changed   = legal && (req_mode != active_mode);
        tick      = (presc_q == PRESC_LAST);
        presc_inc = tick ? '0 : presc_q + PW'(1);
        gain_dn   = {1'b0, gain} - STEP;
        gain_up   = {1'b0, gain} + STEP;

        unique case (state_q)
            RUN: begin
                if (changed) begin
                    target_d = req_mode;
                    state_d  = RAMP_DOWN;
                    presc_d  = '0;
                end
            end
            RAMP_DOWN: begin
                if (legal) target_d = req_mode;
                if (req_mode == active_mode) begin
                    state_d = RAMP_UP;
                    presc_d = '0;
                end else begin
                    presc_d = presc_inc;
                    if (tick) begin
                        // Borrow out of bit 8 means the step overshot zero.
                        if (gain_dn[8] || gain_dn == 9'd0) begin
                            gain_d  = 8'd0;
                            state_d = WAIT_WRAP;
                            tcnt_d  = '0;
                        end else begin
                            gain_d = gain_dn[7:0];
                        end
                    end
                end
            end
            WAIT_WRAP: begin
                gain_d = 8'd0;
                if (legal) target_d = req_mode;
                tcnt_d = tcnt_q + TW'(1);
                if (phase_wrap || tcnt_q == TIMEOUT_LAST) begin
                    mode_d  = legal ? req_mode : target_q;
                    state_d = RAMP_UP;
                    presc_d = '0;
                end
            end
            RAMP_UP: begin
                if (changed) begin
                    target_d = req_mode;
                    state_d  = RAMP_DOWN;
                    presc_d  = '0;
                end else begin
                    presc_d = presc_inc;
                    if (tick) begin
                        if (gain_up >= GAIN_MAX) begin
                            gain_d  = 8'hFF;
                            state_d = RUN;
                        end else begin
                            gain_d = gain_up[7:0];
                        end
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge MHz10) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q     <= RUN;
            target_q    <= 3'd0;
            presc_q     <= '0;
            tcnt_q      <= '0;
            active_mode <= 3'd0;
            gain        <= 8'hFF;
            busy        <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            target_q    <= target_d;
            presc_q     <= presc_d;
            tcnt_q      <= tcnt_d;
            active_mode <= mode_d;
            gain        <= gain_d;
            busy        <= (state_d != RUN);
        end
    end

endmodule

// File: doc/wave_switch_ctrl.md
# wave_switch_ctrl

Glitch-free waveform-switch controller between `wave_selector` and the oscillator/output stage. Watches the requested `wave_mode` and never applies a change instantly. It ramps output gain down to zero, commits the new mode at the oscillator's next period boundary, then ramps gain back up. The oscillator reads `active_mode`; the output multiplier reads `gain`.

## Interface
Parameters:
- `RAMP_DIV`, default 4: clock cycles per gain step; minimum 1.
- `RAMP_STEP`, default 64: gain change per step, 1..255.
- `WRAP_TIMEOUT`, default 1024: maximum cycles spent waiting for `phase_wrap` before a forced commit.

Ports:
- `MHz10` input 1: system clock; all logic on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `en` input 1: block enable. When low, every register holds its value.
- `req_mode` input 3: requested mode from `wave_selector.wave_mode`. Legal values are 0..6; 7 is ignored.
- `phase_wrap` input 1: one-cycle pulse from the oscillator at its period boundary (phase accumulator wrap).
- `active_mode` output 3: registered mode driving the oscillator.
- `gain` output 8: registered output gain; 255 means unity.
- `busy` output 1: registered; high in any state other than RUN.

## Operation
- States: RUN, RAMP_DOWN, WAIT_WRAP, RAMP_UP. State, target, prescaler, timeout counter and all outputs are registers.
- Reset values: state=RUN, `active_mode`=0, `gain`=255, `busy`=0, target=0, prescaler=0, timeout counter=0.
- Prescaler:
  - Cleared to 0 on every entry into RAMP_DOWN or RAMP_UP.
  - Increments each enabled cycle in those states.
  - A tick occurs when it equals RAMP_DIV-1; it then wraps to 0.
- RUN: if `en`, `req_mode`≠7 and `req_mode`≠`active_mode`, latch target=`req_mode` and go to RAMP_DOWN.
- RAMP_DOWN:
  - Each cycle, if `req_mode`≠7, target follows `req_mode`.
  - If `req_mode`==`active_mode`, abort: go to RAMP_UP with gain kept.
  - Otherwise, on a tick, `gain` = max(`gain`−RAMP_STEP, 0). A tick that produces 0 moves to WAIT_WRAP.
- WAIT_WRAP:
  - `gain` stays 0.
  - Timeout counter is cleared on entry and increments each enabled cycle.
  - Commit `active_mode`=target and go to RAMP_UP when either `phase_wrap`=1 or counter==WRAP_TIMEOUT-1.
  - Target still follows legal `req_mode` changes until commit.
  - If `phase_wrap` and a `req_mode` change land in the same cycle, the new `req_mode` is committed.
- RAMP_UP:
  - On a tick, `gain` = min(`gain`+RAMP_STEP, 255). Reaching 255 returns to RUN.
  - If a legal `req_mode`≠`active_mode` appears, latch target and go to RAMP_DOWN from the current gain. This check has priority over the tick in that cycle.
- Arithmetic is 9-bit internally with saturation. `gain` never wraps.
- `en`=0 freezes state, counters and outputs; `phase_wrap` is ignored while `en`=0.
- `rst` mid-operation forces the reset values on the next edge, regardless of `en`.

## Timing
- `busy` rises in the cycle after the RUN→RAMP_DOWN decision, i.e. one cycle after `req_mode` changes.
- Defaults (RAMP_DIV=4, RAMP_STEP=64):
  - Ramp-down sequence 255→191→127→63→0; the first step comes 4 cycles after entering RAMP_DOWN, so 16 cycles total.
  - Ramp-up sequence 0→64→128→192→255, also 16 cycles.
- `active_mode` updates on the edge after the `phase_wrap` pulse is sampled; `gain` is 0 at that moment.
- Minimum switch latency (wrap already present on the WAIT_WRAP entry cycle) is 16+1+16 cycles from RAMP_DOWN entry until `busy` falls.
- RAMP_DIV=1: a step every cycle.
- Combinational paths from inputs to outputs are forbidden.

## Test plan
- Reset, then `req_mode`=0 held 50 cycles → `active_mode`=0, `gain`=255, `busy`=0 throughout.
- `req_mode` 0→1, with `phase_wrap` pulsed 5 cycles after gain reaches 0 → gain 255,191,127,63,0 at 4-cycle spacing. `active_mode`=1 one cycle after the pulse, gain then ramps to 255 and `busy` falls. `active_mode` never changes while gain≠0.
- `req_mode` 0→3, back to 0 after gain=127 → abort to RAMP_UP: gain 127→191→255, `active_mode` stays 0, no WAIT_WRAP entered.
- `req_mode` 0→2 with `phase_wrap` never pulsed → forced commit exactly WRAP_TIMEOUT cycles after entering WAIT_WRAP; `active_mode`=2.
- `req_mode`=7 while in RUN and during RAMP_DOWN → no state change and target unchanged. Change 2→5 during WAIT_WRAP, same cycle as `phase_wrap` → `active_mode`=5.
- `en` dropped mid RAMP_DOWN at gain=127 for 20 cycles → gain and state frozen. Assert `rst` mid RAMP_UP → next cycle state=RUN, `active_mode`=0, `gain`=255, `busy`=0.
